// File: rtl/boot_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states and error codes.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/byte_gap_timer.sv
// Counts idle cycles between accepted stream bytes; flags expiry one cycle
// before the count would reach TIMEOUT_CYCLES. TIMEOUT_CYCLES=0 disables it.
module byte_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, clear, enable};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CW-1:0] cnt;

      // An accept in the same cycle always beats expiry.
      assign expired = enable && !clear && (cnt == CW'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               cnt <= '0;
        else if (!enable || clear) cnt <= '0;
        else if (!expired)        cnt <= cnt + 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: parses length header, assembles big-endian words,
// writes them to instruction memory, verifies an XOR checksum, then releases the core.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 64,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_n,
  output logic        load_done,
  output logic        load_error,
  output logic [1:0]  err_code
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state, nxt;
  logic [1:0]  err_q, err_nxt;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] word_sh;
  logic [7:0]  csum_acc;

  logic        accept, tmo, timer_en, last_word;
  logic [15:0] full_len;

  assign in_ready   = (state == LEN_HI) || (state == LEN_LO) ||
                      (state == DATA)   || (state == CSUM);
  assign accept     = in_valid && in_ready;
  assign cpu_rst_n  = (state == RUN);
  assign load_done  = (state == RUN);
  assign load_error = (state == ERR);
  assign err_code   = err_q;

  assign full_len  = {len_hi, in_data};
  assign last_word = (word_idx == len - 16'd1);
  assign timer_en  = (state == LEN_LO) || (state == DATA) || (state == CSUM);

  byte_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (timer_en),
    .expired(tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    err_nxt = err_q;
    case (state)
      IDLE:   nxt = LEN_HI;
      LEN_HI: if (accept) nxt = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if ({1'b0, full_len} > MAX_N) begin
            nxt     = ERR;
            err_nxt = ERR_LEN;
          end else if (full_len == 16'd0) begin
            nxt = CSUM;
          end else begin
            nxt = DATA;
          end
        end else if (tmo) begin
          nxt     = ERR;
          err_nxt = ERR_TMO;
        end
      end
      DATA: begin
        if (accept) begin
          if (byte_cnt == 2'd3 && last_word) nxt = CSUM;
        end else if (tmo) begin
          nxt     = ERR;
          err_nxt = ERR_TMO;
        end
      end
      CSUM: begin
        if (accept) begin
          if (in_data == csum_acc) begin
            nxt = RUN;
          end else begin
            nxt     = ERR;
            err_nxt = ERR_CSUM;
          end
        end else if (tmo) begin
          nxt     = ERR;
          err_nxt = ERR_TMO;
        end
      end
      RUN:     if (reload) nxt = LEN_HI;
      ERR:     nxt = ERR;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: header capture, word assembly, checksum and the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= ERR_NONE;
      len_hi     <= '0;
      len        <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_sh    <= '0;
      csum_acc   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      err_q   <= err_nxt;
      case (state)
        LEN_HI: if (accept) len_hi <= in_data;
        LEN_LO: if (accept) len <= full_len;
        DATA: begin
          if (accept) begin
            word_sh  <= {word_sh[15:0], in_data};
            csum_acc <= csum_acc ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {word_sh, in_data};
              imem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              word_idx   <= word_idx + 16'd1;
            end
          end
        end
        RUN: begin
          if (reload) begin
            len_hi   <= '0;
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            csum_acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a stream-level reference model.
module tb_imem_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 64;
  localparam int          TMO  = 16;

  logic        clk, rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_ready, reload;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic        cpu_rst_n, load_done, load_error;
  logic [1:0]  err_code;

  imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_error(load_error), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: derived purely from the byte stream and its index.
  logic [7:0]  strm [0:31];
  int          strm_len;
  int          exp_n, exp_total;
  bit          exp_run;
  logic [1:0]  exp_code;
  bit          model_on = 0;
  int          acc_n = 0;
  bit          exp_we = 0;
  logic [31:0] exp_addr, exp_data;

  always @(posedge clk) begin
    if (!model_on) begin
      acc_n  <= 0;
      exp_we <= 0;
    end else if (in_valid && in_ready) begin
      acc_n <= acc_n + 1;
      if (acc_n >= 2 && acc_n < 2 + 4 * exp_n && ((acc_n - 2) % 4) == 3) begin
        exp_we   <= 1;
        exp_addr <= BASE + 32'(4 * ((acc_n - 2) / 4));
        exp_data <= {strm[acc_n-3], strm[acc_n-2], strm[acc_n-1], strm[acc_n]};
      end else begin
        exp_we <= 0;
      end
    end else begin
      exp_we <= 0;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("imem_we", {31'd0, imem_we}, {31'd0, exp_we});
      if (exp_we) begin
        check("imem_addr", imem_addr, exp_addr);
        check("imem_wdata", imem_wdata, exp_data);
      end
      if (acc_n == exp_total) begin
        check("end_done", {31'd0, load_done}, {31'd0, exp_run});
        check("end_error", {31'd0, load_error}, {31'd0, !exp_run});
        check("end_code", {30'd0, err_code}, {30'd0, exp_code});
        check("end_cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, exp_run});
        check("end_in_ready", {31'd0, in_ready}, 32'd0);
      end else begin
        check("mid_done", {31'd0, load_done}, 32'd0);
        check("mid_error", {31'd0, load_error}, 32'd0);
        check("mid_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      end
    end
  end

  int          wr_count = 0;
  logic [31:0] last_addr = '0, last_data = '0;
  always @(negedge clk) begin
    if (imem_we) begin
      wr_count  <= wr_count + 1;
      last_addr <= imem_addr;
      last_data <= imem_wdata;
    end
  end

  // Load a stream given as a left-aligned-by-count hex literal; optionally arm the model.
  task automatic arm(input logic [159:0] v, input int n, input bit use_model);
    logic [7:0] x;
    model_on = 0;
    @(posedge clk); #2;
    strm_len = n;
    for (int i = 0; i < n; i++) strm[i] = v[8*(n-1-i) +: 8];
    exp_n = {strm[0], strm[1]};
    if (exp_n > MAXW) begin
      exp_n = 0; exp_total = 2; exp_run = 0; exp_code = 2'd1;
    end else begin
      x = 8'h00;
      for (int i = 2; i < 2 + 4 * exp_n; i++) x = x ^ strm[i];
      exp_total = 3 + 4 * exp_n;
      exp_run   = (x == strm[2 + 4 * exp_n]);
      exp_code  = exp_run ? 2'd0 : 2'd2;
    end
    model_on = use_model;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    in_valid = 0;
    repeat (gap) begin @(posedge clk); #2; end
    in_valid = 1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #2; guard++; end
    if (!in_ready) check("ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;
    in_valid = 0;
  endtask

  task automatic send_all(input int maxgap, input int count);
    for (int i = 0; i < count; i++)
      send_byte(strm[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    repeat (4) begin @(posedge clk); #2; end
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    check({tag, "_addr"}, imem_addr, BASE);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    check({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_error"}, {31'd0, load_error}, 32'd0);
    check({tag, "_code"}, {30'd0, err_code}, 32'd0);
  endtask

  task automatic do_reset();
    model_on = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1 chk_reset_vals("rst");
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  task automatic do_reload();
    model_on = 0;
    @(posedge clk); #2;
    check("pre_reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    reload = 1;
    @(posedge clk); #2;
    reload = 0;
    check("reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("reload_done", {31'd0, load_done}, 32'd0);
    check("reload_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int wr0, k;
    rst_n = 0; in_valid = 0; in_data = 0; reload = 0;
    #1 chk_reset_vals("por");
    #20 rst_n = 1;

    // N=1, continuous valid
    wr0 = wr_count;
    arm(160'h0001_2008_0005_2D, 7, 1);
    send_all(0, strm_len);
    check("p1_writes", 32'(wr_count - wr0), 32'd1);
    check("p1_addr", last_addr, 32'h0);
    check("p1_data", last_data, 32'h2008_0005);
    check("p1_run", {31'd0, cpu_rst_n & load_done}, 32'd1);

    // N=3 with random gaps below the timeout
    do_reload();
    wr0 = wr_count;
    arm(160'h0003_3C01_1234_3421_5678_AC01_0000_8D, 15, 1);
    send_all(5, strm_len);
    check("p3_writes", 32'(wr_count - wr0), 32'd3);
    check("p3_addr", last_addr, 32'h8);
    check("p3_data", last_data, 32'hAC01_0000);
    check("p3_run", {31'd0, load_done}, 32'd1);

    // N=0, good then bad checksum
    do_reload();
    wr0 = wr_count;
    arm(160'h0000_00, 3, 1);
    send_all(0, strm_len);
    check("n0_run", {31'd0, load_done}, 32'd1);
    do_reload();
    arm(160'h0000_01, 3, 1);
    send_all(0, strm_len);
    check("n0_code", {30'd0, err_code}, 32'd2);
    check("n0_writes", 32'(wr_count - wr0), 32'd0);
    model_on = 0;
    reload = 1; @(posedge clk); #2; reload = 0;
    @(posedge clk); #2;
    check("err_ignores_reload", {31'd0, load_error}, 32'd1);

    // Length overflow
    do_reset();
    wr0 = wr_count;
    arm(160'h0041_0000, 4, 1);
    send_all(0, 2);
    check("ovf_code", {30'd0, err_code}, 32'd1);
    check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    check("ovf_writes", 32'(wr_count - wr0), 32'd0);

    // Timeout after two payload bytes
    do_reset();
    wr0 = wr_count;
    arm(160'h0002_1122_3344_5566_7788_00, 11, 0);
    for (int i = 0; i < 4; i++) send_byte(strm[i], 0);
    k = 0;
    while (!load_error && k < 40) begin @(posedge clk); #2; k++; end
    check("tmo_cycles", 32'(k), 32'd16);
    check("tmo_code", {30'd0, err_code}, 32'd3);
    check("tmo_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check("tmo_writes", 32'(wr_count - wr0), 32'd0);

    // Reset mid-DATA, then a fresh load
    do_reset();
    arm(160'h0001_ABCD_EF01_00, 7, 0);
    for (int i = 0; i < 4; i++) send_byte(strm[i], 0);
    rst_n = 0;
    #1 chk_reset_vals("mid");
    @(posedge clk); #2;
    chk_reset_vals("mid_hold");
    rst_n = 1;
    wr0 = wr_count;
    arm(160'h0001_8C02_0004_8A, 7, 1);
    send_all(0, strm_len);
    check("ar_writes", 32'(wr_count - wr0), 32'd1);
    check("ar_addr", last_addr, BASE);
    check("ar_data", last_data, 32'h8C02_0004);

    // Reload with a second program
    do_reload();
    wr0 = wr_count;
    arm(160'h0002_0102_0304_1020_3040_44, 11, 1);
    send_all(2, strm_len);
    check("rl_writes", 32'(wr_count - wr0), 32'd2);
    check("rl_addr", last_addr, 32'h4);
    check("rl_data", last_data, 32'h1020_3040);
    check("rl_run", {31'd0, load_done}, 32'd1);

    model_on = 0;
    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
